// File: rtl/setare.sv
// setare: time/alarm setting controller between the push-buttons and
// the time/alarm registers; closing a session strobes the matching load.
module setare (
  input  logic       clock,
  input  logic       reset,
  input  logic       semnal_setare,
  input  logic       semnal_setare_a,
  input  logic       semnal_b1,
  input  logic       semnal_b2,
  input  logic       semnal_stop,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic       load_alarma,
  output logic       load_timp
);

  typedef enum logic [2:0] {
    IDLE,
    SET_T,
    SET_A,
    LOAD_T,
    LOAD_A
  } state_t;

  state_t state;

  logic prev_set;
  logic prev_set_a;
  logic prev_b1;
  logic prev_b2;
  logic prev_stop;

  logic rise_set;
  logic rise_set_a;
  logic rise_b1;
  logic rise_b2;
  logic rise_stop;

  logic [4:0] ore_inc;
  logic [5:0] min_inc;

  assign rise_set   = semnal_setare   & ~prev_set;
  assign rise_set_a = semnal_setare_a & ~prev_set_a;
  assign rise_b1    = semnal_b1       & ~prev_b1;
  assign rise_b2    = semnal_b2       & ~prev_b2;
  assign rise_stop  = semnal_stop     & ~prev_stop;

  // Hours and minutes wrap independently; no carry.
  assign ore_inc = (ore == 5'd23) ? 5'd0 : ore + 5'd1;
  assign min_inc = (minute == 6'd59) ? 6'd0 : minute + 6'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ore         <= 5'd0;
      minute      <= 6'd0;
      load_timp   <= 1'b0;
      load_alarma <= 1'b0;
      prev_set    <= 1'b0;
      prev_set_a  <= 1'b0;
      prev_b1     <= 1'b0;
      prev_b2     <= 1'b0;
      prev_stop   <= 1'b0;
    end else begin
      prev_set    <= semnal_setare;
      prev_set_a  <= semnal_setare_a;
      prev_b1     <= semnal_b1;
      prev_b2     <= semnal_b2;
      prev_stop   <= semnal_stop;
      load_timp   <= 1'b0;
      load_alarma <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_set) begin
            state  <= SET_T;
            ore    <= 5'd0;
            minute <= 6'd0;
          end else if (rise_set_a) begin
            state  <= SET_A;
            ore    <= 5'd0;
            minute <= 6'd0;
          end
        end
        SET_T, SET_A: begin
          // Stop freezes the values: same-cycle button edges are dropped.
          if (rise_stop) begin
            state <= (state == SET_T) ? LOAD_T : LOAD_A;
          end else begin
            if (rise_b1) ore <= ore_inc;
            if (rise_b2) minute <= min_inc;
          end
        end
        LOAD_T: begin
          load_timp <= 1'b1;
          state     <= IDLE;
        end
        LOAD_A: begin
          load_alarma <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_setare.sv
// tb_setare: scenario tasks plus randomized traffic checked against a
// session-level model of the set controller.
module tb_setare;

  logic       clock;
  logic       reset;
  logic       semnal_setare;
  logic       semnal_setare_a;
  logic       semnal_b1;
  logic       semnal_b2;
  logic       semnal_stop;
  logic [4:0] ore;
  logic [5:0] minute;
  logic       load_alarma;
  logic       load_timp;

  int total = 0;
  int bad = 0;

  // Model: session 0 none, 1 time, 2 alarm, 3 closing time, 4 closing alarm
  int         m_sess = 0;
  logic [4:0] m_prev = '0;
  int         exp_h = 0;
  int         exp_m = 0;
  int         exp_lt = 0;
  int         exp_la = 0;

  setare dut (
    .clock          (clock),
    .reset          (reset),
    .semnal_setare  (semnal_setare),
    .semnal_setare_a(semnal_setare_a),
    .semnal_b1      (semnal_b1),
    .semnal_b2      (semnal_b2),
    .semnal_stop    (semnal_stop),
    .ore            (ore),
    .minute         (minute),
    .load_alarma    (load_alarma),
    .load_timp      (load_timp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // in = {stop, b2, b1, setare_a, setare}
  task automatic model_clock(input logic rst, input logic [4:0] in);
    logic [4:0] e;
    if (rst) begin
      m_sess = 0;
      m_prev = '0;
      exp_h  = 0;
      exp_m  = 0;
      exp_lt = 0;
      exp_la = 0;
    end else begin
      e      = in & ~m_prev;
      m_prev = in;
      exp_lt = (m_sess == 3) ? 1 : 0;
      exp_la = (m_sess == 4) ? 1 : 0;
      if (m_sess == 0) begin
        if (e[0] || e[1]) begin
          m_sess = e[0] ? 1 : 2;
          exp_h  = 0;
          exp_m  = 0;
        end
      end else if (m_sess <= 2) begin
        if (e[4]) m_sess = m_sess + 2;
        else begin
          if (e[2]) exp_h = (exp_h + 1) % 24;
          if (e[3]) exp_m = (exp_m + 1) % 60;
        end
      end else begin
        m_sess = 0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [4:0] in);
    @(negedge clock);
    reset           = rst;
    semnal_setare   = in[0];
    semnal_setare_a = in[1];
    semnal_b1       = in[2];
    semnal_b2       = in[3];
    semnal_stop     = in[4];
    @(posedge clock);
    model_clock(rst, in);
    #1;
  endtask

  task automatic pulse(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, b);
      step(1'b0, 5'b00000);
    end
  endtask

  task automatic test_reset;
    step(1'b1, 5'b00000);
    step(1'b1, 5'b00000);
    total++;
    if (ore !== 5'd0 || minute !== 6'd0) begin
      bad++;
      $display("FAIL reset_vals: got %0d:%0d want 0:0", ore, minute);
    end
    total++;
    if (load_timp !== 1'b0 || load_alarma !== 1'b0) begin
      bad++;
      $display("FAIL reset_loads: got t=%b a=%b want 0 0",
               load_timp, load_alarma);
    end
  endtask

  task automatic test_time_set;
    step(1'b0, 5'b00001);
    total++;
    if (ore !== 5'd0 || minute !== 6'd0 || load_timp !== 1'b0) begin
      bad++;
      $display("FAIL open_time: got %0d:%0d t=%b want 0:0 t=0",
               ore, minute, load_timp);
    end
    step(1'b0, 5'b00000);
    pulse(5'b00100, 5);
    pulse(5'b01000, 7);
    total++;
    if (ore !== 5'd5 || minute !== 6'd7) begin
      bad++;
      $display("FAIL time_count: got %0d:%0d want 5:7", ore, minute);
    end
    step(1'b0, 5'b10000);
    total++;
    if (load_timp !== 1'b0) begin
      bad++;
      $display("FAIL time_stop_early: got t=%b want 0", load_timp);
    end
    step(1'b0, 5'b00000);
    total++;
    if (load_timp !== 1'b1 || load_alarma !== 1'b0) begin
      bad++;
      $display("FAIL time_strobe: got t=%b a=%b want 1 0",
               load_timp, load_alarma);
    end
    step(1'b0, 5'b00000);
    total++;
    if (load_timp !== 1'b0 || ore !== 5'd5 || minute !== 6'd7) begin
      bad++;
      $display("FAIL time_after: got t=%b %0d:%0d want 0 5:7",
               load_timp, ore, minute);
    end
  endtask

  task automatic test_alarm_wrap;
    int na;
    int nt;
    na = 0;
    nt = 0;
    step(1'b0, 5'b00010);
    total++;
    if (ore !== 5'd0 || minute !== 6'd0) begin
      bad++;
      $display("FAIL open_alarm: got %0d:%0d want 0:0", ore, minute);
    end
    step(1'b0, 5'b00000);
    pulse(5'b00100, 25);
    pulse(5'b01000, 61);
    total++;
    if (ore !== 5'd1 || minute !== 6'd1) begin
      bad++;
      $display("FAIL alarm_wrap: got %0d:%0d want 1:1", ore, minute);
    end
    step(1'b0, 5'b10000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'b00000);
      if (load_alarma === 1'b1) na++;
      if (load_timp === 1'b1) nt++;
    end
    total++;
    if (na != 1 || nt != 0) begin
      bad++;
      $display("FAIL alarm_strobe: got a=%0d t=%0d want a=1 t=0", na, nt);
    end
  endtask

  task automatic test_held_levels;
    int nt;
    nt = 0;
    step(1'b0, 5'b00001);
    step(1'b0, 5'b00101);
    step(1'b0, 5'b00001);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 5'b10001);
      if (load_timp === 1'b1) nt++;
    end
    total++;
    if (nt != 1) begin
      bad++;
      $display("FAIL held_pulses: got %0d want 1", nt);
    end
    total++;
    if (ore !== 5'd1 || minute !== 6'd0) begin
      bad++;
      $display("FAIL held_vals: got %0d:%0d want 1:0", ore, minute);
    end
    step(1'b0, 5'b00000);
  endtask

  task automatic test_same_cycle;
    step(1'b0, 5'b00001);
    step(1'b0, 5'b00000);
    pulse(5'b00100, 2);
    pulse(5'b01000, 3);
    step(1'b0, 5'b11100);
    total++;
    if (ore !== 5'd2 || minute !== 6'd3 || load_timp !== 1'b0) begin
      bad++;
      $display("FAIL same_freeze: got %0d:%0d t=%b want 2:3 t=0",
               ore, minute, load_timp);
    end
    step(1'b0, 5'b00000);
    total++;
    if (load_timp !== 1'b1 || ore !== 5'd2 || minute !== 6'd3) begin
      bad++;
      $display("FAIL same_strobe: got t=%b %0d:%0d want 1 2:3",
               load_timp, ore, minute);
    end
    step(1'b0, 5'b00000);
  endtask

  task automatic test_reset_mid;
    int nl;
    nl = 0;
    step(1'b0, 5'b00001);
    step(1'b0, 5'b00000);
    pulse(5'b00100, 3);
    total++;
    if (ore !== 5'd3) begin
      bad++;
      $display("FAIL mid_count: got %0d want 3", ore);
    end
    step(1'b1, 5'b00000);
    total++;
    if (ore !== 5'd0 || minute !== 6'd0 || load_timp !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got %0d:%0d t=%b want 0:0 t=0",
               ore, minute, load_timp);
    end
    step(1'b0, 5'b00000);
    step(1'b0, 5'b10000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'b00000);
      if (load_timp === 1'b1 || load_alarma === 1'b1) nl++;
    end
    total++;
    if (nl != 0 || ore !== 5'd0) begin
      bad++;
      $display("FAIL mid_stop: got loads=%0d ore=%0d want 0 0", nl, ore);
    end
  endtask

  task automatic test_random;
    logic [4:0] in;
    logic       rst;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 5; b++) in[b] = ($urandom_range(0, 2) == 0);
      if (in[4]) in[4] = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 59) == 0);
      step(rst, in);
      total++;
      if (int'(ore) != exp_h || int'(minute) != exp_m) begin
        bad++;
        $display("FAIL rand_vals n=%0d: got %0d:%0d want %0d:%0d",
                 n, ore, minute, exp_h, exp_m);
      end
      total++;
      if (int'(load_timp) != exp_lt || int'(load_alarma) != exp_la) begin
        bad++;
        $display("FAIL rand_loads n=%0d: got t=%b a=%b want t=%0d a=%0d",
                 n, load_timp, load_alarma, exp_lt, exp_la);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    semnal_setare   = 1'b0;
    semnal_setare_a = 1'b0;
    semnal_b1       = 1'b0;
    semnal_b2       = 1'b0;
    semnal_stop     = 1'b0;
    test_reset();
    test_time_set();
    test_alarm_wrap();
    test_held_levels();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
